// File: rtl/us_sched_pkg.sv
// Shared types and helpers for the ultrasonic ping scheduler.
package us_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_e;

  localparam int DIST_W_MAX = 32;
  localparam logic [DIST_W_MAX-1:0] TMO_SENTINEL = '1;

  // Bits needed to hold 0..n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/us_echo_sync.sv
// Two-flop synchroniser with rise/fall detection for one echo line.
module us_echo_sync (
  input  logic clk,
  input  logic reset,
  input  logic echo_i,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sh_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_q <= '0;
    end else begin
      sh_q <= {sh_q[1:0], echo_i};
    end
  end

  assign rise_o = sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/us_ping_scheduler.sv
// Round-robin trigger/echo sequencer for the pitch and volume rangefinders.
module us_ping_scheduler
  import us_sched_pkg::*;
#(
  parameter int CLK_MHZ    = 100,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int HOLDOFF_US = 10000,
  parameter int W          = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [1:0]   mask,
  input  logic [1:0]   echo,
  output logic [1:0]   trig,
  output logic [W-1:0] dist0_us,
  output logic [W-1:0] dist1_us,
  output logic [1:0]   valid,
  output logic [1:0]   tmo,
  output logic         busy,
  output logic         sel
);

  localparam int PW = cnt_width(CLK_MHZ);
  localparam int LMAX =
    (TIMEOUT_US > HOLDOFF_US) ? TIMEOUT_US : HOLDOFF_US;
  localparam int CMAX = (LMAX > TRIG_US) ? LMAX : TRIG_US;
  localparam int CW = cnt_width(CMAX);

  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_MHZ - 1);
  localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_US - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_US - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_US - 1);
  localparam logic [W-1:0]  DIST_TMO  = TMO_SENTINEL[W-1:0];

  state_e        state_q, state_d;
  logic          sel_q, sel_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] us_q, us_d;
  logic [W-1:0]  dist0_q, dist0_d;
  logic [W-1:0]  dist1_q, dist1_d;
  logic [1:0]    valid_q, valid_d;
  logic [1:0]    tmo_q, tmo_d;
  logic [1:0]    rise, fall;
  logic          tick, moved, wr;
  logic [W-1:0]  wr_val;

  for (genvar g = 0; g < 2; g++) begin : g_sync
    us_echo_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .echo_i(echo[g]),
      .rise_o(rise[g]),
      .fall_o(fall[g])
    );
  end

  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = '0;
    tmo_d   = '0;
    wr      = 1'b0;
    wr_val  = DIST_TMO;
    unique case (state_q)
      IDLE: begin
        if (en && mask != 2'b00) begin
          state_d = TRIG;
          sel_d   = ~mask[0];
        end
      end
      TRIG: begin
        if (tick && us_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (rise[sel_q]) begin
          state_d = MEASURE;
        end else if (tick && us_q == TMO_LAST) begin
          state_d      = HOLDOFF;
          tmo_d[sel_q] = 1'b1;
          wr           = 1'b1;
        end
      end
      MEASURE: begin
        // Timeout wins a tie so a result never reaches TIMEOUT_US.
        if (tick && us_q == TMO_LAST) begin
          state_d      = HOLDOFF;
          tmo_d[sel_q] = 1'b1;
          wr           = 1'b1;
        end else if (fall[sel_q]) begin
          state_d        = HOLDOFF;
          valid_d[sel_q] = 1'b1;
          wr             = 1'b1;
          wr_val         = W'(us_q) + W'(tick);
        end
      end
      HOLDOFF: begin
        if (tick && us_q == HOLD_LAST) begin
          if (!en || mask == 2'b00) begin
            state_d = IDLE;
          end else begin
            state_d = TRIG;
            if (mask[~sel_q]) begin
              sel_d = ~sel_q;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Timebase restarts on every state change so states last whole us.
  assign moved   = (state_d != state_q);
  assign pre_d   = (moved || tick) ? '0 : pre_q + PW'(1);
  assign us_d    = moved ? '0 : us_q + CW'(tick);
  assign dist0_d = (wr && !sel_q) ? wr_val : dist0_q;
  assign dist1_d = (wr && sel_q) ? wr_val : dist1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      pre_q   <= '0;
      us_q    <= '0;
      dist0_q <= '0;
      dist1_q <= '0;
      valid_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pre_q   <= pre_d;
      us_q    <= us_d;
      dist0_q <= dist0_d;
      dist1_q <= dist1_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
    end
  end

  assign trig = (state_q == TRIG)
              ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy     = (state_q != IDLE);
  assign sel      = sel_q;
  assign dist0_us = dist0_q;
  assign dist1_us = dist1_q;
  assign valid    = valid_q;
  assign tmo      = tmo_q;

endmodule

// File: tb/tb_us_ping_scheduler.sv
// Bench for us_ping_scheduler: randomized pings against a ping-level model.
module tb_us_ping_scheduler;

  localparam int CLK_MHZ    = 10;
  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 200;
  localparam int HOLDOFF_US = 50;
  localparam int W          = 16;

  localparam int TRIG_CYC = TRIG_US * CLK_MHZ;
  localparam int TMO_CYC  = TIMEOUT_US * CLK_MHZ;
  localparam int HOLD_CYC = HOLDOFF_US * CLK_MHZ;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         en    = 1'b0;
  logic [1:0]   mask  = 2'b00;
  logic [1:0]   echo  = 2'b00;
  logic [1:0]   trig;
  logic [W-1:0] dist0;
  logic [W-1:0] dist1;
  logic [1:0]   valid;
  logic [1:0]   tmo;
  logic         busy;
  logic         sel;

  int cyc     = 0;
  int checks  = 0;
  int errors  = 0;
  int last_ev = 0;
  int cur     = 0;
  bit noise   = 1'b0;
  logic [W-1:0] pd0, pd1;
  logic [1:0]   sel_oh;

  us_ping_scheduler #(
    .CLK_MHZ   (CLK_MHZ),
    .TRIG_US   (TRIG_US),
    .TIMEOUT_US(TIMEOUT_US),
    .HOLDOFF_US(HOLDOFF_US),
    .W         (W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .mask    (mask),
    .echo    (echo),
    .trig    (trig),
    .dist0_us(dist0),
    .dist1_us(dist1),
    .valid   (valid),
    .tmo     (tmo),
    .busy    (busy),
    .sel     (sel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign sel_oh = sel ? 2'b10 : 2'b01;

  // Invariants that must hold on every cycle out of reset.
  always @(negedge clk) begin
    if (reset) begin
      checks += 3;
      if (trig === 2'b11) begin
        errors++;
        $display("FAIL trig_onehot: trig=%b required one-hot or 0",
                 trig);
      end
      if ((valid & tmo) !== 2'b00 ||
          ((valid | tmo) & ~sel_oh) !== 2'b00) begin
        errors++;
        $display("FAIL strobe_sel: valid=%b tmo=%b sel=%b",
                 valid, tmo, sel);
      end
      if ((dist0 !== pd0 && !(valid[0] | tmo[0])) ||
          (dist1 !== pd1 && !(valid[1] | tmo[1]))) begin
        errors++;
        $display("FAIL dist_hold: d0 %h->%h d1 %h->%h v=%b t=%b",
                 pd0, dist0, pd1, dist1, valid, tmo);
      end
    end
    pd0 <= dist0;
    pd1 <= dist1;
  end

  // Round-robin rule: prefer the other sensor, else repeat.
  function automatic int next_sensor(input int c,
                                     input logic [1:0] m);
    return m[1-c] ? 1 - c : c;
  endfunction

  // One ping on sensor s: echo rises d cycles after trig falls
  // (d<0: never) and stays high l cycles.
  task automatic do_ping(input int s, input int d, input int l,
                         input bit gap, input bit drop);
    int n, t0, w, e, tev, lo, hi;
    bit isv, exp_v;
    logic [1:0] exp_t, evt;
    logic [W-1:0] exp_d, got_d;
    exp_t = (s == 1) ? 2'b10 : 2'b01;
    n = 0;
    while (trig === 2'b00 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (trig !== exp_t || sel !== exp_t[1]) begin
      errors++;
      $display("FAIL trig_target: trig=%b sel=%b required trig=%b",
               trig, sel, exp_t);
      return;
    end
    t0 = cyc;
    if (gap) begin
      checks++;
      if (t0 - last_ev != HOLD_CYC) begin
        errors++;
        $display("FAIL holdoff_gap: got %0d cycles required %0d",
                 t0 - last_ev, HOLD_CYC);
      end
    end
    w = 0;
    while (trig !== 2'b00 && w < 300) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w != TRIG_CYC) begin
      errors++;
      $display("FAIL trig_width: got %0d cycles required %0d",
               w, TRIG_CYC);
    end
    e = cyc;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_ping: busy=%b required 1", busy);
    end
    tev = 0;
    evt = 2'b00;
    isv = 1'b0;
    fork
      begin
        if (d >= 0) begin
          if (noise && d >= 8) begin
            repeat (d - 6) @(negedge clk);
            echo[1-s] = 1'b1;
            repeat (3) @(negedge clk);
            echo[1-s] = 1'b0;
            repeat (3) @(negedge clk);
          end else begin
            repeat (d) @(negedge clk);
          end
          echo[s] = 1'b1;
          if (drop) begin
            repeat (20) @(negedge clk);
            en = 1'b0;
            repeat (l - 20) @(negedge clk);
          end else begin
            repeat (l) @(negedge clk);
          end
          echo[s] = 1'b0;
        end
      end
      begin
        n = 0;
        while ((valid | tmo) === 2'b00 && n < 5000) begin
          @(negedge clk);
          n++;
        end
        tev = cyc;
        evt = valid | tmo;
        isv = (valid !== 2'b00);
      end
    join
    if (d < 0) begin
      exp_v = 1'b0;
      lo = e + TMO_CYC;
      hi = lo;
    end else if (l >= TMO_CYC) begin
      exp_v = 1'b0;
      lo = e + d + TMO_CYC + 3;
      hi = lo + 1;
    end else begin
      exp_v = 1'b1;
      lo = e + d + l + 3;
      hi = lo + 1;
    end
    exp_d = exp_v ? W'(l / CLK_MHZ) : {W{1'b1}};
    got_d = (s == 1) ? dist1 : dist0;
    checks++;
    if (evt !== exp_t || isv !== exp_v) begin
      errors++;
      $display("FAIL event_kind: valid=%b tmo=%b need line %b %s",
               valid, tmo, exp_t, exp_v ? "valid" : "tmo");
    end
    checks++;
    if (tev < lo || tev > hi) begin
      errors++;
      $display("FAIL event_time: at +%0d required +%0d..+%0d",
               tev - e, lo - e, hi - e);
    end
    checks++;
    if (got_d !== exp_d) begin
      errors++;
      $display("FAIL dist%0d: got %h required %h", s, got_d, exp_d);
    end
    last_ev = tev;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en    = 1'b0;
    mask  = 2'b01;
    echo  = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if (trig !== 2'b00 || busy !== 1'b0 || sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: trig=%b busy=%b sel=%b required 0",
               trig, busy, sel);
    end
    checks++;
    if (valid !== 2'b00 || tmo !== 2'b00) begin
      errors++;
      $display("FAIL reset_strobe: valid=%b tmo=%b required 0",
               valid, tmo);
    end
    checks++;
    if (dist0 !== '0 || dist1 !== '0) begin
      errors++;
      $display("FAIL reset_dist: d0=%h d1=%h required 0",
               dist0, dist1);
    end
    reset = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || trig !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_en: busy=%b trig=%b required 0",
               busy, trig);
    end
  endtask

  task automatic test_basic();
    en   = 1'b1;
    mask = 2'b01;
    do_ping(0, 30, 580, 1'b0, 1'b0);
    cur = 0;
    do_ping(0, 100, 250, 1'b1, 1'b0);
  endtask

  task automatic test_alternation();
    mask  = 2'b11;
    noise = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cur = next_sensor(cur, mask);
      do_ping(cur, 20 + 10 * i, 300 + 137 * i, 1'b1, 1'b0);
    end
    noise = 1'b0;
  endtask

  task automatic test_random();
    int d, l;
    for (int i = 0; i < 8; i++) begin
      mask = 2'($urandom_range(1, 3));
      cur  = next_sensor(cur, mask);
      d    = int'($urandom_range(0, 300));
      if ($urandom_range(0, 3) == 0) begin
        l = int'($urandom_range(TMO_CYC, TMO_CYC + 300));
      end else begin
        l = int'($urandom_range(5, TMO_CYC - 1));
      end
      do_ping(cur, d, l, 1'b1, 1'b0);
    end
  endtask

  task automatic test_no_echo();
    mask = 2'b10;
    cur  = next_sensor(cur, mask);
    do_ping(cur, -1, 0, 1'b1, 1'b0);
  endtask

  task automatic test_stuck();
    mask    = 2'b01;
    echo[0] = 1'b1;
    cur     = next_sensor(cur, mask);
    do_ping(cur, -1, 0, 1'b1, 1'b0);
    echo[0] = 1'b0;
  endtask

  task automatic test_disable();
    int n;
    bit seen;
    mask = 2'b01;
    cur  = next_sensor(cur, mask);
    do_ping(cur, 40, 600, 1'b1, 1'b1);
    n = 0;
    while (cyc < last_ev + HOLD_CYC - 1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL dis_holdoff: busy=%b required 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || trig !== 2'b00) begin
      errors++;
      $display("FAIL dis_idle: busy=%b trig=%b required 0 0",
               busy, trig);
    end
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (trig !== 2'b00 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL dis_quiet: activity=%b required 0", seen);
    end
  endtask

  task automatic test_async_reset();
    int n;
    mask = 2'b11;
    en   = 1'b1;
    n    = 0;
    while (trig[0] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (trig !== 2'b01) begin
      errors++;
      $display("FAIL arst_start: trig=%b required 01", trig);
    end
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (trig !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_now: trig=%b busy=%b required 0 0",
               trig, busy);
    end
    checks++;
    if (dist0 !== '0 || dist1 !== '0 || sel !== 1'b0) begin
      errors++;
      $display("FAIL arst_regs: d0=%h d1=%h sel=%b required 0",
               dist0, dist1, sel);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    do_ping(0, 20, 300, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alternation();
    test_random();
    test_no_echo();
    test_stuck();
    test_disable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not end by 90000 cycles");
    $fatal(1);
  end

endmodule
